// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N-channel stream multiplexer.
// Optional feature macro used by this slice: STREAM_MUX_BEAT_CNT_EN (per-packet beat index output).
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int BEAT_CNT_W = 16;
    localparam int FILL_MAX_W = 64;

    // All-ones pattern of the requested width, right-aligned in a wide word
    function automatic logic [FILL_MAX_W-1:0] fill_of(input int width);
        logic [FILL_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < FILL_MAX_W; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/stream_mux_out_reg.sv
// Single-entry registered output stage with valid/ready handshake.
// Optional feature macro: STREAM_MUX_BEAT_CNT_EN adds a beat-index field to the payload.
module stream_mux_out_reg
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_data,
    input  logic                  load_last,
    input  logic                  load_err,
    input  logic [SEL_W-1:0]      load_ch,
`ifdef STREAM_MUX_BEAT_CNT_EN
    input  logic [BEAT_CNT_W-1:0] load_beat,
    output logic [BEAT_CNT_W-1:0] out_beat,
`endif
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic                  out_err,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  slot_free
);

    assign slot_free = !out_valid || out_ready;

    // Capture a new beat when loaded, otherwise drop valid once the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            out_ch    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
            out_err   <= load_err;
            out_ch    <= load_ch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUX_BEAT_CNT_EN
    // Beat index travels with the rest of the payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_beat <= '0;
        end else if (load) begin
            out_beat <= load_beat;
        end
    end
`endif

endmodule

// File: rtl/stream_mux_n.sv
// N-channel streaming multiplexer: a select request locks one input lane for a whole
// packet and forwards its beats through a single registered output stage; an
// out-of-range select emits one FILL error beat per cycle instead of data.
// Optional feature macro: STREAM_MUX_BEAT_CNT_EN (adds out_beat, beat index in packet).
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int              N_CH  = 9,
    parameter int              WIDTH = 16,
    parameter int              SEL_W = 4,
    parameter logic [WIDTH-1:0] FILL = WIDTH'(fill_of(WIDTH))
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  sel_valid,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [WIDTH-1:0]      in_data [N_CH],
    input  logic [N_CH-1:0]       in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic                  out_err,
`ifdef STREAM_MUX_BEAT_CNT_EN
    output logic [BEAT_CNT_W-1:0] out_beat,
`endif
    output logic [SEL_W-1:0]      out_ch
);

    localparam logic [SEL_W:0] N_CH_CODE = (SEL_W+1)'(N_CH);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] lock_sel, lock_sel_nxt;
    logic [SEL_W-1:0] cur_sel;
    logic             in_range;
    logic             grant;
    logic             slot_free;
    logic             transfer;
    logic             fill_req;
    logic             load;
    logic [WIDTH-1:0] mux_data;
    logic             mux_last;
    logic [WIDTH-1:0] load_data;
    logic             load_last;

    assign cur_sel  = (state == LOCKED) ? lock_sel : sel;
    assign in_range = {1'b0, cur_sel} < N_CH_CODE;
    assign grant    = rst_n && slot_free && in_range && (state == LOCKED || sel_valid);
    assign fill_req = rst_n && (state == IDLE) && sel_valid && !in_range && slot_free;
    assign transfer = |(in_valid & in_ready);
    assign load     = transfer || fill_req;

    // Select the active lane's payload and raise ready only on that lane
    always_comb begin
        in_ready = '0;
        mux_data = '0;
        mux_last = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_sel == SEL_W'(k)) begin
                in_ready[k] = grant;
                mux_data    = in_data[k];
                mux_last    = in_last[k];
            end
        end
    end

    assign load_data = fill_req ? FILL : mux_data;
    assign load_last = fill_req ? 1'b1 : mux_last;

    // Packet lock register: holds the owning lane until its last beat transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_sel <= '0;
        end else begin
            state    <= state_nxt;
            lock_sel <= lock_sel_nxt;
        end
    end

    // Next-state: lock on a non-final first beat, release on the final beat
    always_comb begin
        state_nxt    = state;
        lock_sel_nxt = lock_sel;
        case (state)
            IDLE: begin
                if (transfer && !mux_last) begin
                    state_nxt    = LOCKED;
                    lock_sel_nxt = sel;
                end
            end
            LOCKED: begin
                if (transfer && mux_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef STREAM_MUX_BEAT_CNT_EN
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [BEAT_CNT_W-1:0] load_beat;

    assign load_beat = fill_req ? '0 : beat_cnt;

    // Index of the next beat in the packet; saturates and clears after the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (transfer) begin
            if (mux_last)
                beat_cnt <= '0;
            else if (beat_cnt != '1)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end
`endif

    stream_mux_out_reg #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .load_err  (fill_req),
        .load_ch   (cur_sel),
`ifdef STREAM_MUX_BEAT_CNT_EN
        .load_beat (load_beat),
        .out_beat  (out_beat),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_err   (out_err),
        .out_ch    (out_ch),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard testbench for stream_mux_n (N_CH=9, WIDTH=16, SEL_W=4).
// Honours STREAM_MUX_BEAT_CNT_EN when defined (checks out_beat too).
module tb_stream_mux_n;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sel;
    logic        sel_valid;
    logic [8:0]  in_valid;
    logic [8:0]  in_ready;
    logic [15:0] in_data [9];
    logic [8:0]  in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_err;
    logic [3:0]  out_ch;
`ifdef STREAM_MUX_BEAT_CNT_EN
    logic [15:0] out_beat;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        err;
        logic [3:0]  ch;
        logic [15:0] beat;
    } exp_t;

    exp_t sb[$];
    int   assert_count = 0;
    int   fail_count   = 0;

    stream_mux_n #(.N_CH(9), .WIDTH(16), .SEL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .sel_valid (sel_valid),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_err   (out_err),
`ifdef STREAM_MUX_BEAT_CNT_EN
        .out_beat  (out_beat),
`endif
        .out_ch    (out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Producer on lane ch: sends up to max_beats of an n-beat packet, pushing each accepted beat
    task automatic applyStimulus(input int ch, input int n, input logic [15:0] base, input int max_beats);
        logic rdy;
        bit   accepted;
        int   waited;
        sel       = 4'(ch);
        sel_valid = 1'b1;
        for (int i = 0; i < n && i < max_beats; i++) begin
            in_valid[ch] = 1'b1;
            in_data[ch]  = base + 16'(i);
            in_last[ch]  = (i == n - 1);
            accepted = 0;
            waited   = 0;
            while (!accepted && waited < 50) begin
                @(negedge clk);
                rdy = in_ready[ch];
                @(posedge clk);
                #1;
                if (rdy) accepted = 1;
                else     waited++;
            end
            if (!accepted) begin
                checkOutput("accept_timeout", 32'd0, 32'd1);
                in_valid[ch] = 1'b0;
                sel_valid    = 1'b0;
                return;
            end
            sb.push_back('{data: base + 16'(i), last: (i == n - 1), err: 1'b0, ch: 4'(ch), beat: 16'(i)});
            checkOutput("latency_valid", 32'(out_valid), 32'd1);
            checkOutput("latency_data", 32'(out_data), 32'(base + 16'(i)));
        end
        if (max_beats >= n) begin
            in_valid[ch] = 1'b0;
            in_last[ch]  = 1'b0;
            sel_valid    = 1'b0;
        end
    endtask

    initial begin
        exp_t        e;
        bit          prev_stall;
        logic [15:0] prev_data;
        prev_stall = 0;
        prev_data  = '0;
        rst_n      = 1'b0;
        sel        = 4'd0;
        sel_valid  = 1'b1;
        in_valid   = '0;
        in_last    = '0;
        out_ready  = 1'b1;
        for (int k = 0; k < 9; k++) in_data[k] = '0;
        fork
            // Output monitor: stall/hold rules and scoreboard comparison
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    checkOutput("ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);
                    if (out_valid && !out_ready) begin
                        checkOutput("stall_ready", 32'(in_ready), 32'd0);
                        if (prev_stall) checkOutput("stall_hold", 32'(out_data), 32'(prev_data));
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_data  = out_data;
                    if (out_valid && out_ready) begin
                        if (sb.size() == 0) begin
                            checkOutput("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
                        end else begin
                            e = sb.pop_front();
                            checkOutput("out_data", 32'(out_data), 32'(e.data));
                            checkOutput("out_last", 32'(out_last), 32'(e.last));
                            checkOutput("out_err", 32'(out_err), 32'(e.err));
                            checkOutput("out_ch", 32'(out_ch), 32'(e.ch));
`ifdef STREAM_MUX_BEAT_CNT_EN
                            checkOutput("out_beat", 32'(out_beat), 32'(e.beat));
`endif
                        end
                    end
                end else begin
                    prev_stall = 0;
                end
            end
            begin
                // Reset values, with a live in-range request that must not raise ready
                #12;
                checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
                checkOutput("rst_out_data", 32'(out_data), 32'd0);
                checkOutput("rst_out_last", 32'(out_last), 32'd0);
                checkOutput("rst_out_err", 32'(out_err), 32'd0);
                checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
                checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
                sel_valid = 1'b0;
                @(negedge clk);
                #2;
                rst_n = 1'b1;
                @(posedge clk);
                #1;

                $display("[TB] basic 3-beat packet on ch3");
                applyStimulus(3, 3, 16'hA001, 99);

                $display("[TB] select change while locked");
                fork
                    applyStimulus(3, 5, 16'hB000, 99);
                    begin
                        repeat (2) @(posedge clk);
                        #1;
                        sel         = 4'd5;
                        in_valid[5] = 1'b1;
                        in_data[5]  = 16'hC000;
                        in_last[5]  = 1'b1;
                        repeat (2) begin
                            @(negedge clk);
                            checkOutput("nonsel_ready", 32'(in_ready[5]), 32'd0);
                        end
                    end
                join
                applyStimulus(5, 1, 16'hC001, 99);

                $display("[TB] out-of-range select");
                sel       = 4'd12;
                sel_valid = 1'b1;
                sb.push_back('{data: 16'hFFFF, last: 1'b1, err: 1'b1, ch: 4'd12, beat: 16'd0});
                @(negedge clk);
                checkOutput("fill_no_ready", 32'(in_ready), 32'd0);
                @(posedge clk);
                #1;
                sel_valid = 1'b0;
                checkOutput("fill_valid", 32'(out_valid), 32'd1);
                checkOutput("fill_err", 32'(out_err), 32'd1);
                repeat (3) @(posedge clk);
                #1;

                $display("[TB] backpressure during packet");
                fork
                    applyStimulus(6, 6, 16'hD000, 99);
                    begin
                        repeat (2) @(posedge clk);
                        #1;
                        out_ready = 1'b0;
                        repeat (4) @(posedge clk);
                        #1;
                        out_ready = 1'b1;
                    end
                join

                $display("[TB] async reset mid-packet");
                applyStimulus(2, 6, 16'hE000, 3);
                #3;
                rst_n = 1'b0;
                sb.delete();
                #1;
                checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
                checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
                in_valid[2] = 1'b0;
                in_last[2]  = 1'b0;
                sel_valid   = 1'b0;
                @(negedge clk);
                #2;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                applyStimulus(0, 3, 16'hF000, 99);

                $display("[TB] packet beat numbering");
                applyStimulus(1, 5, 16'h1000, 99);
                applyStimulus(4, 2, 16'h2000, 99);

                repeat (5) @(posedge clk);
                #1;
                checkOutput("sb_drained", 32'(sb.size()), 32'd0);
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
